// File: rtl/morningjava_seg7_reader.sv
// Debounced 7-segment reader: synchronizes a raw segment pattern, waits for it to
// stay stable, decodes it to a hex nibble and holds the result until acknowledged.
module morningjava_seg7_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] segments,
  input  logic       ack_in,
  output logic [3:0] data_out,
  output logic       dp_out,
  output logic       valid_out,
  output logic       error_out,
  output logic       overrun_out
);

  // Handshake: valid_out rises with a committed report and stays high until a
  // cycle where ack_in is sampled high; a new commit always wins over ack_in.

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  state_t     state, state_next;
  logic [7:0] s1, s2;
  logic [7:0] cand, cand_next;
  logic [7:0] cnt, cnt_next;
  logic [7:0] last, last_next;
  logic       commit;
  logic [3:0] dec_nibble;
  logic       dec_err;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= 8'h00;
      s2          <= 8'h00;
      state       <= IDLE;
      cand        <= 8'h00;
      cnt         <= 8'h00;
      last        <= 8'h00;
      data_out    <= 4'h0;
      dp_out      <= 1'b0;
      error_out   <= 1'b0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      s1    <= segments;
      s2    <= s1;
      state <= state_next;
      cand  <= cand_next;
      cnt   <= cnt_next;
      last  <= last_next;
      if (commit) begin
        data_out  <= dec_nibble;
        dp_out    <= cand[7];
        error_out <= dec_err;
        valid_out <= 1'b1;
        if (valid_out && !ack_in) begin
          overrun_out <= 1'b1;
        end
      end else if (ack_in && valid_out) begin
        valid_out <= 1'b0;
      end
    end
  end

  // Next-state: any change of s2 restarts the settle window
  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    last_next  = last;
    commit     = 1'b0;
    if (s2 != cand) begin
      cand_next  = s2;
      cnt_next   = 8'h00;
      state_next = SETTLE;
    end else if (state == SETTLE) begin
      if (cnt < CNT_MAX) begin
        cnt_next = cnt + 8'd1;
      end else begin
        state_next = IDLE;
        last_next  = cand;
        commit     = (cand != last) && (cand[6:0] != 7'h00);
      end
    end
  end

  // Output decode of the settled candidate
  always_comb begin
    dec_nibble = 4'h0;
    dec_err    = 1'b0;
    case (cand[6:0])
      7'h3F: dec_nibble = 4'h0;
      7'h06: dec_nibble = 4'h1;
      7'h5B: dec_nibble = 4'h2;
      7'h4F: dec_nibble = 4'h3;
      7'h66: dec_nibble = 4'h4;
      7'h6D: dec_nibble = 4'h5;
      7'h7D: dec_nibble = 4'h6;
      7'h07: dec_nibble = 4'h7;
      7'h7F: dec_nibble = 4'h8;
      7'h67: dec_nibble = 4'h9;
      7'h77: dec_nibble = 4'hA;
      7'h7C: dec_nibble = 4'hB;
      7'h39: dec_nibble = 4'hC;
      7'h5E: dec_nibble = 4'hD;
      7'h79: dec_nibble = 4'hE;
      7'h71: dec_nibble = 4'hF;
      default: begin
        dec_nibble = 4'h0;
        dec_err    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_morningjava_seg7_reader.sv
// Directed bench for morningjava_seg7_reader: stimulus pushes expected reports,
// a monitor pops and compares each report the DUT presents.
module tb_morningjava_seg7_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] segments;
  logic       ack_in;
  logic [3:0] data_out;
  logic       dp_out;
  logic       valid_out;
  logic       error_out;
  logic       overrun_out;

  int checks       = 0;
  int errors       = 0;
  int reports_seen = 0;
  int pushes       = 0;

  // entry layout: {overrun, error, dp, data[3:0]}
  logic [6:0] exp_q[$];

  morningjava_seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .segments   (segments),
    .ack_in     (ack_in),
    .data_out   (data_out),
    .dp_out     (dp_out),
    .valid_out  (valid_out),
    .error_out  (error_out),
    .overrun_out(overrun_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // scoreboard monitor: a report is a rise of valid_out or new outputs while valid
  logic       prev_valid = 1'b0;
  logic [5:0] prev_out   = 6'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_out   = 6'h00;
    end else begin
      if (valid_out && (!prev_valid || {error_out, dp_out, data_out} != prev_out)) begin
        reports_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_report actual=%0h required=none",
                   {overrun_out, error_out, dp_out, data_out});
        end else begin
          check("report", {25'h0, overrun_out, error_out, dp_out, data_out}, {25'h0, exp_q.pop_front()});
        end
      end
      prev_valid = valid_out;
      prev_out   = {error_out, dp_out, data_out};
    end
  end

  // driver tasks
  task automatic push_exp(input logic [3:0] d, input logic dp, input logic err, input logic ov);
    exp_q.push_back({ov, err, dp, d});
    pushes++;
  endtask

  task automatic set_seg(input logic [7:0] v);
    @(negedge clk);
    segments = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_reports(input string name);
    int n = 0;
    while (reports_seen < pushes && n < 60) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check(name, reports_seen, pushes);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack_in = 1'b1;
    @(negedge clk);
    ack_in = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_data"}, data_out, 0);
    check({name, "_dp"}, dp_out, 0);
    check({name, "_valid"}, valid_out, 0);
    check({name, "_error"}, error_out, 0);
    check({name, "_overrun"}, overrun_out, 0);
  endtask

  initial begin
    rst      = 1'b1;
    segments = 8'h00;
    ack_in   = 1'b0;
    idle(3);
    check_all_zero("reset");
    rst = 1'b0;
    idle(3);

    // exact latency: change before edge k, valid after edge k+6
    push_exp(4'h2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    segments = 8'h5B;
    repeat (6) @(posedge clk);
    #1 check("latency_early", valid_out, 0);
    @(posedge clk);
    #1 check("latency_on_time", valid_out, 1);
    wait_reports("wait_5b");
    do_ack();
    check("ack_clears_valid", valid_out, 0);
    check("ack_holds_data", data_out, 2);

    // decimal point and undecodable pattern
    push_exp(4'h4, 1'b1, 1'b0, 1'b0);
    set_seg(8'hE6);
    wait_reports("wait_e6");
    do_ack();
    push_exp(4'h0, 1'b0, 1'b1, 1'b0);
    set_seg(8'h1F);
    wait_reports("wait_1f");
    do_ack();
    check("error_held_after_ack", error_out, 1);

    // bouncing input never settles, then holds 0x4F
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      segments = (i % 2 == 1) ? 8'h4F : 8'h06;
      @(negedge clk);
    end
    check("toggle_quiet", reports_seen, pushes);
    push_exp(4'h3, 1'b0, 1'b0, 1'b0);
    wait_reports("wait_4f");
    do_ack();

    // two reports without ack -> overrun
    push_exp(4'h0, 1'b0, 1'b0, 1'b0);
    set_seg(8'h3F);
    wait_reports("wait_3f");
    push_exp(4'hF, 1'b0, 1'b0, 1'b1);
    set_seg(8'h71);
    wait_reports("wait_71");
    check("overrun_valid", valid_out, 1);
    check("overrun_set", overrun_out, 1);
    do_ack();
    check("overrun_sticky", overrun_out, 1);

    // same digit held does not re-report; a stable blank re-arms it
    push_exp(4'h6, 1'b0, 1'b0, 1'b1);
    set_seg(8'h7D);
    wait_reports("wait_7d");
    do_ack();
    idle(12);
    check("no_rereport", reports_seen, pushes);
    check("no_rereport_valid", valid_out, 0);
    set_seg(8'h00);
    idle(10);
    check("blank_no_report", reports_seen, pushes);
    push_exp(4'h6, 1'b0, 1'b0, 1'b1);
    set_seg(8'h7D);
    wait_reports("wait_7d_again");

    // reset mid-settle with a report pending
    @(negedge clk);
    segments = 8'h06;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_exp(4'h1, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1 check("post_reset_early", valid_out, 0);
    @(posedge clk);
    #1 check("post_reset_on_time", valid_out, 1);
    wait_reports("wait_06");
    do_ack();
    idle(4);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morningjava_seg7_reader.md
MORNINGJAVA_SEG7_READER -- requirements
Module: morningjava_seg7_reader

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive cycles a pattern must hold before it is reported; legal range 1..255.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port segments  input  8  raw 7-segment pattern in bit order p,g,f,e,d,c,b,a (bit7..bit0), asynchronous to clk.
REQ-005 The block SHALL have port ack_in  input  1  consumer acknowledge; clears a pending report.
REQ-006 The block SHALL have port data_out  output  4  decoded hex nibble of the last report.
REQ-007 The block SHALL have port dp_out  output  1  decimal-point bit (segments[7]) of the last report.
REQ-008 The block SHALL have port valid_out  output  1  high while a report is pending.
REQ-009 The block SHALL have port error_out  output  1  last report's pattern (bits 6..0) was not in the decode table.
REQ-010 The block SHALL have port overrun_out  output  1  sticky; a report was overwritten before ack_in.

Function
REQ-011 segments SHALL pass through a 2-flop synchronizer; all further logic uses the second stage (s2).
REQ-012 Decode table (bits 6..0 -> nibble) SHALL be: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 67->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
REQ-013 Any other non-zero bits 6..0 value SHALL decode to data_out=0 with error_out=1; pattern 0x00 (blank, any dp) SHALL never generate a report.
REQ-014 FSM SHALL have two states, IDLE and SETTLE, plus registers cand[7:0], cnt[7:0], last[7:0].
REQ-015 In any state, if s2 != cand: cand<=s2, cnt<=0, state<=SETTLE (restarts the settle window).
REQ-016 In SETTLE with s2 == cand and cnt < STABLE_CYCLES-1: cnt<=cnt+1.
REQ-017 In SETTLE with s2 == cand and cnt == STABLE_CYCLES-1: state<=IDLE; if cand != last and cand[6:0] != 0, commit a report; last<=cand in either case.
REQ-018 Commit SHALL load data_out, dp_out, error_out from cand and set valid_out=1 on the same edge.
REQ-019 Latency: a clean change of segments before rising edge k SHALL produce valid_out=1 after edge k+STABLE_CYCLES+2.
REQ-020 ack_in sampled high while valid_out=1 SHALL clear valid_out on that edge; data_out/dp_out/error_out SHALL hold their values.
REQ-021 ack_in while valid_out=0 SHALL be ignored.
REQ-022 Commit while valid_out=1 without ack_in on the same edge SHALL overwrite outputs, keep valid_out=1, and set overrun_out=1.
REQ-023 Commit coincident with ack_in SHALL take priority: outputs load new values, valid_out stays 1, overrun_out unchanged.
REQ-024 overrun_out SHALL clear only on reset.
REQ-025 Returning to a pattern equal to last SHALL not re-report; an intervening stable blank (0x00) SHALL update last, so the same digit reports again afterwards.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, synchronizer flops, cand, cnt, last to 0, and data_out=0, dp_out=0, valid_out=0, error_out=0, overrun_out=0.
REQ-027 Reset asserted mid-SETTLE or with a report pending SHALL discard both; first report after release follows REQ-019.

Verification
REQ-028 STABLE_CYCLES=4, segments 0x00->0x5B at edge 10 -> valid_out=1 after edge 16, data_out=2, dp_out=0, error_out=0.
REQ-029 segments=0xE6 held -> data_out=4, dp_out=1; then 0x1F held -> data_out=0, error_out=1.
REQ-030 segments toggles 0x06/0x4F every 2 cycles for 20 cycles, then holds 0x4F -> no report during toggling; one report data_out=3 after settle.
REQ-031 Two distinct stable patterns 0x3F then 0x71, no ack_in -> second report data_out=F, valid_out=1, overrun_out=1.
REQ-032 0x7D stable, ack_in pulse, 0x7D unchanged -> valid_out=0 and no re-report; via 0x00 back to 0x7D -> new report data_out=6.
REQ-033 rst pulsed 2 cycles after segments change (mid-settle) -> all outputs 0 at once; report follows REQ-019 after release.
